// File: rtl/sseg_scan_mux.sv
// sseg_scan_mux: time-multiplexed common-anode seven-segment driver with hex decode,
// per-digit blanking, decimal points and per-frame input snapshots.
// Latency: outputs follow the scan index after one register stage; no backpressure (free-running).
// Optional macro SSEG_LZ_SUPPRESS_EN enables leading-zero suppression on the snapshot.
module sseg_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     blank,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  output logic [6:0]                sseg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic                      live_q;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   val_q;
  logic [NUM_DIGITS-1:0]     blank_q;
  logic [NUM_DIGITS-1:0]     snap_dp_q;
  logic [NUM_DIGITS-1:0]     blank_eff;
  logic [NUM_DIGITS-1:0]     an_q, an_d;
  logic [6:0]                sseg_q, sseg_d;
  logic                      dpo_q, dpo_d;
  logic [3:0]                code;
  logic                      dig_blank;
  logic                      dig_dp;

  function automatic logic [6:0] decode(input logic [3:0] c);
    case (c)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0010000;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b1000110;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  // Refresh counter and scan index; held until the first snapshot so digit 0 gets a full dwell.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    load  = !live_q;
    if (live_q) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        if (idx_q == IDX_MAX) begin
          idx_d = '0;
          load  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

`ifdef SSEG_LZ_SUPPRESS_EN
  logic lead;
  // Leading-zero suppression: walk down from the top digit until a nonzero code or a lit dp.
  always_comb begin
    lead      = 1'b1;
    blank_eff = blank_q;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (lead && (val_q[4*i +: 4] == 4'h0) && !snap_dp_q[i]) begin
        blank_eff[i] = 1'b1;
      end else begin
        lead = 1'b0;
      end
    end
  end
`else
  assign blank_eff = blank_q;
`endif

  // Select the snapshot entry at the current index and form the next pin values.
  always_comb begin
    code      = 4'h0;
    dig_blank = 1'b1;
    dig_dp    = 1'b0;
    an_d      = '1;
    sseg_d    = 7'b1111111;
    dpo_d     = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) == idx_q) begin
        code      = val_q[4*i +: 4];
        dig_blank = blank_eff[i];
        dig_dp    = snap_dp_q[i];
      end
    end
    if (live_q && !dig_blank) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (IW'(i) == idx_q) an_d[i] = 1'b0;
      end
      sseg_d = decode(code);
      dpo_d  = ~dig_dp;
    end
  end

  // State, snapshot and output registers; reset darkens the display immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      live_q    <= 1'b0;
      val_q     <= '0;
      blank_q   <= '0;
      snap_dp_q <= '0;
      an_q      <= '1;
      sseg_q    <= 7'b1111111;
      dpo_q     <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      live_q <= 1'b1;
      if (load) begin
        val_q     <= value;
        blank_q   <= blank;
        snap_dp_q <= dp_in;
      end
      an_q   <= an_d;
      sseg_q <= sseg_d;
      dpo_q  <= dpo_d;
    end
  end

  assign an   = an_q;
  assign sseg = sseg_q;
  assign dp   = dpo_q;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Testbench for sseg_scan_mux (NUM_DIGITS=4, REFRESH_DIV=3): directed stimulus pushes
// cycle-tagged expected pin values into a scoreboard; a monitor on the falling edge pops and compares.
module tb_sseg_scan_mux;

  localparam logic [6:0] DARK = 7'b1111111;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  blank;
  logic [3:0]  dp_in;
  logic [6:0]  sseg;
  logic        dp;
  logic [3:0]  an;

  typedef struct {
    int          cyc;
    string       name;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic        dp;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   ecnt;
  int   n_cmp;
  int   n_mis;
  logic drain;
  logic drained;

  sseg_scan_mux #(.NUM_DIGITS(4), .REFRESH_DIV(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .value (value),
    .blank (blank),
    .dp_in (dp_in),
    .sseg  (sseg),
    .dp    (dp),
    .an    (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  task automatic exp_at(input int c, input string nm, input logic [3:0] a,
                        input logic [6:0] s, input logic d);
    exp_t e;
    e.cyc  = c;
    e.name = nm;
    e.an   = a;
    e.sseg = s;
    e.dp   = d;
    sb.push_back(e);
  endtask

  task automatic go(input int n);
    int guard;
    guard = 0;
    while (ecnt < n) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 1000) begin
        $display("FAIL go_timeout: ecnt=%0d required=%0d", ecnt, n);
        $fatal(1);
      end
    end
  endtask

  // Monitor: compare the head entry whose cycle tag matches the current edge count.
  always @(negedge clk) begin
    if (drain && !drained) begin
      if (sb.size() > 0) begin
        n_cmp = n_cmp + sb.size();
        n_mis = n_mis + sb.size();
        $display("FAIL unchecked: %0d entries left, required 0 (head %s)", sb.size(), sb[0].name);
      end
      drained = 1'b1;
    end else if (sb.size() > 0 && sb[0].cyc == ecnt) begin
      mon_e = sb.pop_front();
      n_cmp++;
      if (an !== mon_e.an || sseg !== mon_e.sseg || dp !== mon_e.dp) begin
        n_mis++;
        $display("FAIL %s cyc%0d: an=%b sseg=%b dp=%b required an=%b sseg=%b dp=%b",
                 mon_e.name, ecnt, an, sseg, dp, mon_e.an, mon_e.sseg, mon_e.dp);
      end
    end
  end

  initial begin
    n_cmp   = 0;
    n_mis   = 0;
    drain   = 1'b0;
    drained = 1'b0;
    rst_n   = 1'b0;
    value   = 16'h1234;
    blank   = 4'b0000;
    dp_in   = 4'b0000;

    // Startup, dwell and tear-free update (value changes to 5678 at idx=1).
    exp_at(0,  "reset_dark", 4'b1111, DARK,       1'b1);
    exp_at(1,  "edge1_dark", 4'b1111, DARK,       1'b1);
    exp_at(2,  "d0_is_4",    4'b1110, 7'b0011001, 1'b1);
    exp_at(4,  "d0_hold",    4'b1110, 7'b0011001, 1'b1);
    exp_at(5,  "d1_is_3",    4'b1101, 7'b0110000, 1'b1);
    exp_at(8,  "d2_old_2",   4'b1011, 7'b0100100, 1'b1);
    exp_at(11, "d3_old_1",   4'b0111, 7'b1111001, 1'b1);
    exp_at(14, "d0_new_8",   4'b1110, 7'b0000000, 1'b1);
    exp_at(17, "d1_new_7",   4'b1101, 7'b1111000, 1'b1);
    exp_at(20, "d2_new_6",   4'b1011, 7'b0000010, 1'b1);
    exp_at(23, "d3_new_5",   4'b0111, 7'b0010010, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    go(6);
    value = 16'h5678;

    // Hex letters, change lands just before the frame-boundary load at edge 25.
    go(24);
    value = 16'hABCD;
    exp_at(26, "hex_d",      4'b1110, 7'b0100001, 1'b1);
    exp_at(29, "hex_c",      4'b1101, 7'b1000110, 1'b1);
    exp_at(32, "hex_b",      4'b1011, 7'b0000011, 1'b1);
    exp_at(35, "hex_a",      4'b0111, 7'b0001000, 1'b1);

    // Blanking of digit 2 and decimal point on digit 0.
    go(36);
    blank = 4'b0100;
    dp_in = 4'b0001;
    exp_at(38, "d0_dp_on",   4'b1110, 7'b0100001, 1'b0);
    exp_at(40, "d0_dp_hold", 4'b1110, 7'b0100001, 1'b0);
    exp_at(41, "d1_dp_off",  4'b1101, 7'b1000110, 1'b1);
    exp_at(44, "d2_blank",   4'b1111, DARK,       1'b1);
    exp_at(47, "d3_lit",     4'b0111, 7'b0001000, 1'b1);

    // Clear blank/dp, then reset mid-scan while internal idx=2.
    go(48);
    blank = 4'b0000;
    dp_in = 4'b0000;
    exp_at(50, "d0_dp_clr",  4'b1110, 7'b0100001, 1'b1);
    exp_at(53, "d1_pre_rst", 4'b1101, 7'b1000110, 1'b1);
    go(55);
    exp_at(0,  "midrst_dark", 4'b1111, DARK, 1'b1);
    rst_n = 1'b0;
    value = 16'h0040;

    // Restart and leading-zero behaviour with value 0040.
    exp_at(1,  "re_edge1",   4'b1111, DARK,       1'b1);
    exp_at(2,  "re_d0_0",    4'b1110, 7'b1000000, 1'b1);
    exp_at(5,  "re_d1_4",    4'b1101, 7'b0011001, 1'b1);
`ifdef SSEG_LZ_SUPPRESS_EN
    exp_at(8,  "lz_d2_dark", 4'b1111, DARK,       1'b1);
    exp_at(11, "lz_d3_dark", 4'b1111, DARK,       1'b1);
`else
    exp_at(8,  "re_d2_0",    4'b1011, 7'b1000000, 1'b1);
    exp_at(11, "re_d3_0",    4'b0111, 7'b1000000, 1'b1);
`endif
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge clk);
    drain = 1'b1;
    for (int i = 0; i < 10 && !drained; i++) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
